// File: rtl/decode_regfile_sb.sv
// Decode-stage register file with byte-enable write-back, same-cycle bypass
// and a per-entry scoreboard of results still in flight.
module decode_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     rs,
    input  logic [ADDR_W-1:0]     rt,
    output logic [DATA_W-1:0]     dataA,
    output logic [DATA_W-1:0]     dataB,
    input  logic                  r_write,
    input  logic [ADDR_W-1:0]     rd,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_be,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_rd,
    output logic                  busyA,
    output logic                  busyB,
    output logic                  stall,
    output logic [ADDR_W:0]       pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;
    logic [ADDR_W:0]   pend_cnt_next;
    logic [DATA_W-1:0] merged;
    logic              write_ok;
    logic              clear_ok;
    logic              issue_ok;
    logic              zero_a;
    logic              zero_b;

    // A write during reset is discarded, so it must not bypass or clear busy either.
    assign write_ok = r_write && !rst && !((ZERO_REG != 0) && (rd == '0));
    assign clear_ok = write_ok && (w_be != '0);
    assign issue_ok = iss_en && !((ZERO_REG != 0) && (iss_rd == '0));
    assign zero_a   = (ZERO_REG != 0) && (rs == '0);
    assign zero_b   = (ZERO_REG != 0) && (rt == '0);

    always_comb begin
        merged = mem[rd];
        for (int i = 0; i < NB; i++) begin
            if (w_be[i]) begin
                merged[8*i +: 8] = w_data[8*i +: 8];
            end
        end
    end

    assign dataA = zero_a ? '0 : ((write_ok && rd == rs) ? merged : mem[rs]);
    assign dataB = zero_b ? '0 : ((write_ok && rd == rt) ? merged : mem[rt]);
    assign busyA = pending[rs] && !(clear_ok && rd == rs);
    assign busyB = pending[rt] && !(clear_ok && rd == rt);
    assign stall = busyA || busyB;

    // Clear is applied before set so a same-edge reissue leaves the entry pending.
    always_comb begin
        pending_next = pending;
        if (clear_ok) begin
            pending_next[rd] = 1'b0;
        end
        if (issue_ok) begin
            pending_next[iss_rd] = 1'b1;
        end
        pend_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_next = pend_cnt_next + (ADDR_W+1)'(pending_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (write_ok) begin
                mem[rd] <= merged;
            end
            pending  <= pending_next;
            pend_cnt <= pend_cnt_next;
        end
    end

endmodule

// File: tb/tb_decode_regfile_sb.sv
// Self-checking bench for decode_regfile_sb: directed vector table, a reset
// corner sequence, then random traffic against a behavioural model.
module tb_decode_regfile_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  rs, rt, rd, iss_rd;
    logic [31:0] dataA, dataB, w_data;
    logic        r_write, iss_en;
    logic [3:0]  w_be;
    logic        busyA, busyB, stall;
    logic [4:0]  pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    decode_regfile_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .dataA(dataA), .dataB(dataB),
        .r_write(r_write), .rd(rd), .w_data(w_data), .w_be(w_be),
        .iss_en(iss_en), .iss_rd(iss_rd), .busyA(busyA), .busyB(busyB),
        .stall(stall), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          rst_i, wr, rd_i;
        logic [31:0] wd;
        int          be, ise, isr, rs_i, rt_i;
        logic [31:0] ea, eb;
        int          eba, ebb, est, ecnt;
    } vec_t;

    vec_t vecs[20];

    // Behavioural model: plain word array plus a set of in-flight destinations.
    logic [31:0] m_mem [16];
    bit          m_pend [16];
    int          m_cnt;

    function automatic vec_t mk(input int rst_i, wr, rd_i, input logic [31:0] wd,
                                input int be, ise, isr, rs_i, rt_i,
                                input logic [31:0] ea, eb, input int eba, ebb, est, ecnt);
        vec_t v;
        v.rst_i = rst_i; v.wr = wr; v.rd_i = rd_i; v.wd = wd; v.be = be;
        v.ise = ise; v.isr = isr; v.rs_i = rs_i; v.rt_i = rt_i;
        v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb; v.est = est; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int rst_i, wr, rd_i, input logic [31:0] wd,
                         input int be, ise, isr, rs_i, rt_i);
        @(negedge clk);
        rst = 1'(rst_i); r_write = 1'(wr); rd = 4'(rd_i); w_data = wd;
        w_be = 4'(be); iss_en = 1'(ise); iss_rd = 4'(isr); rs = 4'(rs_i); rt = 4'(rt_i);
    endtask

    task automatic apply_stimulus(input vec_t v);
        drive(v.rst_i, v.wr, v.rd_i, v.wd, v.be, v.ise, v.isr, v.rs_i, v.rt_i);
    endtask

    task automatic check_output(input vec_t v, input string tag);
        check({tag, " dataA"}, dataA, v.ea);
        check({tag, " dataB"}, dataB, v.eb);
        check({tag, " busyA"}, 32'(busyA), 32'(v.eba));
        check({tag, " busyB"}, 32'(busyB), 32'(v.ebb));
        check({tag, " stall"}, 32'(stall), 32'(v.est));
        check({tag, " pend_cnt"}, 32'(pend_cnt), 32'(v.ecnt));
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8*i));
        return m;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] mask = be_mask(w_be);
        if (a == 4'd0) return 32'h0;
        if (r_write && !rst && rd == a) return (m_mem[a] & ~mask) | (w_data & mask);
        return m_mem[a];
    endfunction

    function automatic bit model_busy(input logic [3:0] a);
        return m_pend[a] && !(r_write && !rst && rd == a && w_be != 4'd0);
    endfunction

    task automatic model_update();
        logic [31:0] mask = be_mask(w_be);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
        end else begin
            if (r_write && rd != 4'd0) begin
                m_mem[rd] = (m_mem[rd] & ~mask) | (w_data & mask);
                if (w_be != 4'd0) m_pend[rd] = 0;
            end
            if (iss_en && iss_rd != 4'd0) m_pend[iss_rd] = 1;
        end
        m_cnt = 0;
        for (int i = 0; i < 16; i++) m_cnt += int'(m_pend[i]);
    endtask

    initial begin
        vecs[0]  = mk(0,0,0,32'h0,0,0,0, 3,9, 32'h0,32'h0, 0,0,0,0);
        vecs[1]  = mk(0,1,3,32'hDEADBEEF,15,0,0, 3,0, 32'hDEADBEEF,32'h0, 0,0,0,0);
        vecs[2]  = mk(0,0,0,32'h0,0,0,0, 3,0, 32'hDEADBEEF,32'h0, 0,0,0,0);
        vecs[3]  = mk(0,1,5,32'h11223344,15,0,0, 0,0, 32'h0,32'h0, 0,0,0,0);
        vecs[4]  = mk(0,1,5,32'hAABBCCDD,5,0,0, 5,0, 32'h11BB33DD,32'h0, 0,0,0,0);
        vecs[5]  = mk(0,0,0,32'h0,0,0,0, 5,3, 32'h11BB33DD,32'hDEADBEEF, 0,0,0,0);
        vecs[6]  = mk(0,0,0,32'h0,0,1,7, 0,7, 32'h0,32'h0, 0,0,0,0);
        vecs[7]  = mk(0,0,0,32'h0,0,0,0, 0,7, 32'h0,32'h0, 0,1,1,1);
        vecs[8]  = mk(0,1,7,32'hCAFEF00D,15,0,0, 0,7, 32'h0,32'hCAFEF00D, 0,0,0,1);
        vecs[9]  = mk(0,0,0,32'h0,0,0,0, 0,7, 32'h0,32'hCAFEF00D, 0,0,0,0);
        vecs[10] = mk(0,1,0,32'hFFFFFFFF,15,1,0, 0,0, 32'h0,32'h0, 0,0,0,0);
        vecs[11] = mk(0,0,0,32'h0,0,0,0, 0,0, 32'h0,32'h0, 0,0,0,0);
        vecs[12] = mk(0,1,2,32'h5,15,1,2, 2,0, 32'h5,32'h0, 0,0,0,0);
        vecs[13] = mk(0,0,0,32'h0,0,0,0, 2,0, 32'h5,32'h0, 1,0,1,1);
        vecs[14] = mk(0,1,2,32'h99,0,0,0, 2,0, 32'h5,32'h0, 1,0,1,1);
        vecs[15] = mk(0,0,0,32'h0,0,0,0, 2,0, 32'h5,32'h0, 1,0,1,1);
        vecs[16] = mk(0,1,2,32'h77,15,1,4, 2,4, 32'h77,32'h0, 0,0,0,1);
        vecs[17] = mk(0,0,0,32'h0,0,0,0, 2,4, 32'h77,32'h0, 0,1,1,1);
        vecs[18] = mk(0,0,0,32'h0,0,1,4, 0,4, 32'h0,32'h0, 0,1,1,1);
        vecs[19] = mk(0,0,0,32'h0,0,0,0, 0,4, 32'h0,32'h0, 0,1,1,1);

        rst = 1'b1; r_write = 0; rd = 0; w_data = 0; w_be = 0;
        iss_en = 0; iss_rd = 0; rs = 0; rt = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset lands on the third of three back-to-back issues, with a write in flight.
        drive(0,0,0,32'h0,0,1,1, 0,0);  #1; check("seq iss1 pend_cnt", 32'(pend_cnt), 32'd1);
        drive(0,0,0,32'h0,0,1,2, 0,0);  #1; check("seq iss2 pend_cnt", 32'(pend_cnt), 32'd2);
        drive(1,1,6,32'h1234,15,1,3, 6,0); #1;
        check("seq rst pend_cnt", 32'(pend_cnt), 32'd3);
        check("seq rst no bypass", dataA, 32'h0);
        drive(0,0,0,32'h0,0,0,0, 1,3);  #1;
        check("post rst pend_cnt", 32'(pend_cnt), 32'd0);
        check("post rst dataA", dataA, 32'h0);
        check("post rst dataB", dataB, 32'h0);
        check("post rst stall", 32'(stall), 32'd0);
        check("post rst busyA", 32'(busyA), 32'd0);
        drive(0,0,0,32'h0,0,0,0, 6,5);  #1;
        check("post rst entry6", dataA, 32'h0);
        check("post rst entry5", dataB, 32'h0);
        check("post rst pend_cnt2", 32'(pend_cnt), 32'd0);

        for (int i = 0; i < 16; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
        m_cnt = 0;

        for (int c = 0; c < 1500; c++) begin
            int r_rd, r_rs, r_rt;
            r_rd = $urandom_range(0, 15);
            r_rs = ($urandom_range(0, 3) == 0) ? r_rd : $urandom_range(0, 15);
            r_rt = ($urandom_range(0, 3) == 0) ? r_rd : $urandom_range(0, 15);
            drive(($urandom_range(0, 63) == 0) ? 1 : 0, $urandom_range(0, 1), r_rd, $urandom,
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 15), r_rs, r_rt);
            #1;
            check("rnd dataA", dataA, model_read(rs));
            check("rnd dataB", dataB, model_read(rt));
            check("rnd busyA", 32'(busyA), 32'(model_busy(rs)));
            check("rnd busyB", 32'(busyB), 32'(model_busy(rt)));
            check("rnd stall", 32'(stall), 32'(model_busy(rs) || model_busy(rt)));
            check("rnd pend_cnt", 32'(pend_cnt), 32'(m_cnt));
            model_update();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
